except_commit: RTL and testbench

- Consumer end of the exception pipeline: receives the `ExceptStruct::ExceptPack` at the commit point, after the last `ExceptReg` stage.
- On a trap, commits `mepc`/`mcause`/`mtval`/`mstatus` through a single CSR write port as a timed sequence, then redirects fetch to the trap vector and flushes the pipeline.
- Also sequences `mret`: restores `mstatus` and redirects to `mepc`.
- Holds the pipeline stalled for the whole sequence.

---
 rtl/except_commit.sv | 200 ++++++++++++++++++++
 tb/tb_except_commit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/except_commit.sv
// Commit-point exception sequencer: writes the trap CSRs through one write
// port over successive cycles, then redirects fetch and flushes the pipeline.
module except_commit #(
    parameter int          XLEN         = 64,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MTVAL_ADDR   = 12'h343
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [192:0]    except_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mstatus_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [XLEN-1:0] trap_count_o
);

    // state    | meaning
    // IDLE     | waiting for an exception or mret at commit
    // W_EPC    | trap: write mepc
    // W_CAUSE  | trap: write mcause
    // W_TVAL   | trap: write mtval
    // W_STATUS | trap: write mstatus (MIE->MPIE, MIE=0, MPP=M)
    // M_STATUS | mret: write mstatus (MPIE->MIE, MPIE=1, MPP=U)
    // REDIRECT | redirect fetch and flush, one cycle
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_EPC    = 3'd1,
        W_CAUSE  = 3'd2,
        W_TVAL   = 3'd3,
        W_STATUS = 3'd4,
        M_STATUS = 3'd5,
        REDIRECT = 3'd6
    } state_e;

    state_e state_q, state_d;

    logic            pk_except;
    logic [XLEN-1:0] pk_epc, pk_ecause, pk_etval;

    assign pk_except = except_i[192];
    assign pk_epc    = except_i[191:128];
    assign pk_ecause = except_i[127:64];
    assign pk_etval  = except_i[63:0];

    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] ecause_q, ecause_d;
    logic [XLEN-1:0] etval_q, etval_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic            is_mret_q, is_mret_d;
    logic [XLEN-1:0] trap_count_q, trap_count_d;

    // State and latch register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            epc_q        <= '0;
            ecause_q     <= '0;
            etval_q      <= '0;
            mstatus_q    <= '0;
            mtvec_q      <= '0;
            mepc_q       <= '0;
            is_mret_q    <= 1'b0;
            trap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            ecause_q     <= ecause_d;
            etval_q      <= etval_d;
            mstatus_q    <= mstatus_d;
            mtvec_q      <= mtvec_d;
            mepc_q       <= mepc_d;
            is_mret_q    <= is_mret_d;
            trap_count_q <= trap_count_d;
        end
    end

    // Next-state and latch capture; inputs only matter in IDLE
    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        ecause_d     = ecause_q;
        etval_d      = etval_q;
        mstatus_d    = mstatus_q;
        mtvec_d      = mtvec_q;
        mepc_d       = mepc_q;
        is_mret_d    = is_mret_q;
        trap_count_d = trap_count_q;
        case (state_q)
            IDLE: begin
                if (pk_except) begin
                    epc_d     = pk_epc;
                    ecause_d  = pk_ecause;
                    etval_d   = pk_etval;
                    mstatus_d = mstatus_i;
                    mtvec_d   = mtvec_i;
                    is_mret_d = 1'b0;
                    state_d   = W_EPC;
                end else if (mret_i) begin
                    mstatus_d = mstatus_i;
                    mepc_d    = mepc_i;
                    is_mret_d = 1'b1;
                    state_d   = M_STATUS;
                end
            end
            W_EPC: begin
                trap_count_d = trap_count_q + 1'b1;
                state_d      = W_CAUSE;
            end
            W_CAUSE:  state_d = W_TVAL;
            W_TVAL:   state_d = W_STATUS;
            W_STATUS: state_d = REDIRECT;
            M_STATUS: state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    logic [XLEN-1:0] trap_status, mret_status, tvec_base, trap_pc;

    always_comb begin
        trap_status        = mstatus_q;
        trap_status[7]     = mstatus_q[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;
        mret_status        = mstatus_q;
        mret_status[3]     = mstatus_q[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b00;
    end

    // Vectored mode only applies to interrupts; exceptions use the base
    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_pc   = (mtvec_q[1:0] == 2'b01 && ecause_q[XLEN-1])
                     ? tvec_base + {ecause_q[XLEN-3:0], 2'b00}
                     : tvec_base;

    // Output decode
    always_comb begin
        csr_we_o         = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        stall_o          = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        case (state_q)
            W_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = MEPC_ADDR;
                csr_wdata_o = epc_q;
                stall_o     = 1'b1;
            end
            W_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = MCAUSE_ADDR;
                csr_wdata_o = ecause_q;
                stall_o     = 1'b1;
            end
            W_TVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = MTVAL_ADDR;
                csr_wdata_o = etval_q;
                stall_o     = 1'b1;
            end
            W_STATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = MSTATUS_ADDR;
                csr_wdata_o = trap_status;
                stall_o     = 1'b1;
            end
            M_STATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = MSTATUS_ADDR;
                csr_wdata_o = mret_status;
                stall_o     = 1'b1;
            end
            REDIRECT: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = is_mret_q ? mepc_q : trap_pc;
            end
            default: ;
        endcase
    end

    assign trap_count_o = trap_count_q;

endmodule

// File: tb/tb_except_commit.sv
// Directed bench for except_commit: trap, vectored interrupt, mret, priority,
// ignored inputs, mid-sequence reset and back-to-back traps.
module tb_except_commit;

    logic         clk;
    logic         rst;
    logic [192:0] except_i;
    logic         mret_i;
    logic [63:0]  mtvec_i, mepc_i, mstatus_i;
    logic         csr_we_o;
    logic [11:0]  csr_waddr_o;
    logic [63:0]  csr_wdata_o;
    logic         stall_o, flush_o, redirect_valid_o;
    logic [63:0]  redirect_pc_o, trap_count_o;

    int checks = 0;
    int errors = 0;

    except_commit dut (
        .clk              (clk),
        .rst              (rst),
        .except_i         (except_i),
        .mret_i           (mret_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .mstatus_i        (mstatus_i),
        .csr_we_o         (csr_we_o),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .trap_count_o     (trap_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [192:0] pack(input logic e, input logic [63:0] epc,
                                          input logic [63:0] cause, input logic [63:0] tval);
        return {e, epc, cause, tval};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic we, input logic [11:0] addr,
                            input logic [63:0] data, input logic stall, input logic flush,
                            input logic rv, input logic [63:0] pc);
        chk({tag, ".we"},    64'(csr_we_o),         64'(we));
        chk({tag, ".addr"},  64'(csr_waddr_o),      64'(addr));
        chk({tag, ".data"},  csr_wdata_o,           data);
        chk({tag, ".stall"}, 64'(stall_o),          64'(stall));
        chk({tag, ".flush"}, 64'(flush_o),          64'(flush));
        chk({tag, ".rv"},    64'(redirect_valid_o), 64'(rv));
        chk({tag, ".pc"},    redirect_pc_o,         pc);
    endtask

    task automatic chk_idle(input string tag);
        chk_outs(tag, 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    // Called right after the accepting edge; walks the write and redirect cycles.
    task automatic expect_trap(input string tag, input logic [63:0] epc,
                               input logic [63:0] cause, input logic [63:0] tval,
                               input logic [63:0] stat, input logic [63:0] pc,
                               input logic [63:0] cnt);
        chk_outs({tag, ".epc"}, 1'b1, 12'h341, epc, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        chk_outs({tag, ".cause"}, 1'b1, 12'h342, cause, 1'b1, 1'b0, 1'b0, 64'h0);
        chk({tag, ".cnt"}, trap_count_o, cnt);
        tick();
        chk_outs({tag, ".tval"}, 1'b1, 12'h343, tval, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        chk_outs({tag, ".status"}, 1'b1, 12'h300, stat, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        chk_outs({tag, ".redir"}, 1'b0, 12'h0, 64'h0, 1'b0, 1'b1, 1'b1, pc);
        chk({tag, ".cnt_r"}, trap_count_o, cnt);
        tick();
        chk_idle({tag, ".idle"});
    endtask

    initial begin
        rst = 1'b0;
        except_i = '0;
        mret_i = 1'b0;
        mtvec_i = '0;
        mepc_i = '0;
        mstatus_i = '0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset.cnt", trap_count_o, 64'h0);
        rst = 1'b1;
        tick();
        chk_idle("idle0");

        // Basic trap
        except_i  = pack(1'b1, 64'h8000_0010, 64'h2, 64'hDEAD);
        mtvec_i   = 64'h8000_0100;
        mstatus_i = 64'h8;
        tick();
        except_i  = '0;
        mtvec_i   = 64'h0;
        mstatus_i = 64'h0;
        expect_trap("trap", 64'h8000_0010, 64'h2, 64'hDEAD, 64'h1880, 64'h8000_0100, 64'd1);

        // Vectored interrupt
        except_i  = pack(1'b1, 64'h8000_0020, 64'h8000_0000_0000_0007, 64'h0);
        mtvec_i   = 64'h8000_0101;
        mstatus_i = 64'h0;
        tick();
        except_i  = '0;
        expect_trap("vec", 64'h8000_0020, 64'h8000_0000_0000_0007, 64'h0, 64'h1800,
                    64'h8000_011C, 64'd2);

        // Vectored mtvec with a synchronous exception uses the base
        except_i  = pack(1'b1, 64'h40, 64'h5, 64'h77);
        mtvec_i   = 64'h8000_0101;
        mstatus_i = 64'h0;
        tick();
        except_i  = '0;
        expect_trap("vecexc", 64'h40, 64'h5, 64'h77, 64'h1800, 64'h8000_0100, 64'd3);

        // mret
        mret_i    = 1'b1;
        mstatus_i = 64'h1880;
        mepc_i    = 64'h8000_0014;
        tick();
        mret_i    = 1'b0;
        mstatus_i = 64'h0;
        mepc_i    = 64'h0;
        chk_outs("mret.status", 1'b1, 12'h300, 64'h88, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        chk_outs("mret.redir", 1'b0, 12'h0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h8000_0014);
        chk("mret.cnt", trap_count_o, 64'd3);
        tick();
        chk_idle("mret.idle");

        // Exception beats simultaneous mret; second exception in W_CAUSE ignored
        except_i  = pack(1'b1, 64'h100, 64'h3, 64'h9);
        mret_i    = 1'b1;
        mtvec_i   = 64'h8000_0200;
        mepc_i    = 64'h1234;
        mstatus_i = 64'h8;
        tick();
        except_i  = '0;
        mret_i    = 1'b0;
        chk_outs("prio.epc", 1'b1, 12'h341, 64'h100, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        chk_outs("prio.cause", 1'b1, 12'h342, 64'h3, 1'b1, 1'b0, 1'b0, 64'h0);
        except_i  = pack(1'b1, 64'h999, 64'h4, 64'h1);
        tick();
        except_i  = '0;
        chk_outs("prio.tval", 1'b1, 12'h343, 64'h9, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        chk_outs("prio.status", 1'b1, 12'h300, 64'h1880, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        chk_outs("prio.redir", 1'b0, 12'h0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h8000_0200);
        chk("prio.cnt", trap_count_o, 64'd4);
        tick();
        chk_idle("prio.idle");
        tick();
        chk_idle("prio.idle2");
        chk("prio.cnt2", trap_count_o, 64'd4);

        // Reset at the edge entering W_TVAL aborts the sequence
        except_i  = pack(1'b1, 64'h500, 64'h6, 64'h7);
        mtvec_i   = 64'h300;
        mstatus_i = 64'h0;
        tick();
        except_i  = '0;
        tick();
        chk_outs("rst.cause", 1'b1, 12'h342, 64'h6, 1'b1, 1'b0, 1'b0, 64'h0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_idle("rst.abort");
        chk("rst.cnt", trap_count_o, 64'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_idle("rst.quiet");
        end
        except_i  = pack(1'b1, 64'h600, 64'h1, 64'h2);
        mtvec_i   = 64'h8000_0400;
        mstatus_i = 64'h8;
        tick();
        except_i  = '0;
        expect_trap("after_rst", 64'h600, 64'h1, 64'h2, 64'h1880, 64'h8000_0400, 64'd1);

        // Back-to-back: exception held high is taken every 6 cycles
        except_i  = pack(1'b1, 64'h700, 64'hB, 64'hC);
        mtvec_i   = 64'h8000_0500;
        mstatus_i = 64'h0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            chk("b2b.stall", 64'(stall_o), 64'h1);
            chk("b2b.rv_lo", 64'(redirect_valid_o), 64'h0);
            tick();
        end
        chk("b2b.stall5", 64'(stall_o), 64'h0);
        chk("b2b.rv5", 64'(redirect_valid_o), 64'h1);
        chk("b2b.pc5", redirect_pc_o, 64'h8000_0500);
        tick();
        chk("b2b.stall6", 64'(stall_o), 64'h0);
        chk("b2b.rv6", 64'(redirect_valid_o), 64'h0);
        chk("b2b.cnt6", trap_count_o, 64'd2);
        tick();
        except_i  = '0;
        expect_trap("b2b2", 64'h700, 64'hB, 64'hC, 64'h1800, 64'h8000_0500, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
